// File: rtl/percept_seq_if.sv
// Stream, result and percept-side signals shared by the sequencer and its environment.
// master is the sequencer's view; slave is the view of the store, consumer and percept.
interface percept_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_in;
  logic [DW-1:0] s_weight;
  logic          p_clr;
  logic          p_write;
  logic [DW-1:0] p_in;
  logic [DW-1:0] p_weight;
  logic [OW-1:0] p_out;
  logic          r_valid;
  logic          r_ready;
  logic [OW-1:0] r_data;

  modport master (
    input  s_valid, s_in, s_weight, p_out, r_ready,
    output s_ready, p_clr, p_write, p_in, p_weight, r_valid, r_data
  );

  modport slave (
    output s_valid, s_in, s_weight, p_out, r_ready,
    input  s_ready, p_clr, p_write, p_in, p_weight, r_valid, r_data
  );
endinterface

// File: rtl/percept_seq.sv
// Batch sequencer for the percept MAC: clear, then setup/strobe each accepted pair,
// let the accumulator settle, and hand the captured result out on a valid/ready port.
module percept_seq #(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DW          = 8,
  parameter int unsigned OW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  percept_seq_if.master bus,
  output logic          busy
);
  localparam int unsigned CW      = $clog2(N_INPUTS + 1);
  // Zero settle cycles still needs one cycle to capture p_out.
  localparam int unsigned WaitLen = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
  localparam int unsigned WW      = (WaitLen > 1) ? $clog2(WaitLen) : 1;

  typedef enum logic [2:0] {
    StIdle, StClear, StAccept, StSetup, StStrobe, StWait, StResult
  } state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [WW-1:0] wait_q;
  logic          s_ready_q, p_clr_q, p_write_q, r_valid_q, busy_q;
  logic [DW-1:0] p_in_q, p_weight_q;
  logic [OW-1:0] r_data_q;

  // All outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wait_q     <= '0;
      s_ready_q  <= 1'b0;
      p_clr_q    <= 1'b0;
      p_write_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      p_in_q     <= '0;
      p_weight_q <= '0;
      r_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.s_valid) begin
            p_clr_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          p_clr_q   <= 1'b0;
          count_q   <= '0;
          s_ready_q <= 1'b1;
          state_q   <= StAccept;
        end
        StAccept: begin
          if (bus.s_valid && s_ready_q) begin
            p_in_q     <= bus.s_in;
            p_weight_q <= bus.s_weight;
            s_ready_q  <= 1'b0;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          p_write_q <= 1'b1;
          state_q   <= StStrobe;
        end
        StStrobe: begin
          p_write_q <= 1'b0;
          count_q   <= count_q + 1'b1;
          if (count_q == CW'(N_INPUTS - 1)) begin
            wait_q  <= WW'(WaitLen - 1);
            state_q <= StWait;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= StAccept;
          end
        end
        StWait: begin
          if (wait_q == '0) begin
            r_data_q  <= bus.p_out;
            r_valid_q <= 1'b1;
            state_q   <= StResult;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StResult: begin
          if (bus.r_ready) begin
            r_valid_q <= 1'b0;
            if (bus.s_valid) begin
              p_clr_q <= 1'b1;
              state_q <= StClear;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.p_clr    = p_clr_q;
  assign bus.p_write  = p_write_q;
  assign bus.p_in     = p_in_q;
  assign bus.p_weight = p_weight_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_data   = r_data_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_percept_seq.sv
// Randomised scoreboard bench for percept_seq: a 4-pair/2-wait instance and a
// 1-pair/0-wait instance, each driving a behavioural percept accumulator.
module tb_percept_seq;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  always #5 clk = ~clk;

  percept_seq_if #(.DW(DW), .OW(OW)) a_if ();
  percept_seq_if #(.DW(DW), .OW(OW)) b_if ();

  percept_seq #(.N_INPUTS(4), .WAIT_CYCLES(2), .DW(DW), .OW(OW)) u_a (
    .clk(clk), .rst(rst), .bus(a_if.master), .busy(busy_a)
  );
  percept_seq #(.N_INPUTS(1), .WAIT_CYCLES(0), .DW(DW), .OW(OW)) u_b (
    .clk(clk), .rst(rst), .bus(b_if.master), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Percept models: accumulate on p_write rise, clear on p_clr.
  logic [OW-1:0] acc_a, acc_b;
  logic          pw_prev_a, pw_prev_b;
  logic          force_ff = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      acc_a <= '0; pw_prev_a <= 1'b0;
      acc_b <= '0; pw_prev_b <= 1'b0;
    end else begin
      pw_prev_a <= a_if.p_write;
      pw_prev_b <= b_if.p_write;
      if (a_if.p_clr) acc_a <= '0;
      else if (a_if.p_write && !pw_prev_a)
        acc_a <= acc_a + {8'd0, a_if.p_in} * {8'd0, a_if.p_weight};
      if (b_if.p_clr) acc_b <= '0;
      else if (b_if.p_write && !pw_prev_b)
        acc_b <= acc_b + {8'd0, b_if.p_in} * {8'd0, b_if.p_weight};
    end
  end
  assign a_if.p_out = force_ff ? 16'hFFFF : acc_a;
  assign b_if.p_out = acc_b;

  // Result consumer for A: 0 always ready, 1 random, 2 stalled.
  int rr_mode = 0;
  initial begin
    a_if.r_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       a_if.r_ready = 1'b1;
        1:       a_if.r_ready = 1'($urandom_range(0, 1));
        default: a_if.r_ready = 1'b0;
      endcase
    end
  end

  // Scoreboards and monitors.
  logic [OW-1:0] exp_a[$];
  logic [OW-1:0] exp_b[$];
  logic          prev_rv, prev_rr, prev_pw;
  logic [DW-1:0] prev_pin, prev_pwt;
  int            clr_cnt, strobe_cnt;

  always @(negedge clk) begin
    if (rst) begin
      clr_cnt = 0; strobe_cnt = 0;
      prev_rv = 1'b0; prev_rr = 1'b0; prev_pw = 1'b0;
      prev_pin = '0; prev_pwt = '0;
    end else begin
      if (a_if.p_clr) begin
        clr_cnt++;
        strobe_cnt = 0;
      end
      if (a_if.p_write) begin
        strobe_cnt++;
        check("strobe_after_low_setup", {31'd0, prev_pw}, 32'd0);
        check("pair_stable_setup_to_strobe", {16'd0, prev_pin, prev_pwt},
              {16'd0, a_if.p_in, a_if.p_weight});
      end
      if (prev_rv && prev_rr) check("r_valid_drops_after_handshake", {31'd0, a_if.r_valid}, 32'd0);
      if (a_if.r_valid) begin
        check("s_ready_low_in_result", {31'd0, a_if.s_ready}, 32'd0);
        check("busy_in_result", {31'd0, busy_a}, 32'd1);
      end
      if (a_if.r_valid && a_if.r_ready) begin
        check("result_was_expected", {31'd0, exp_a.size() > 0}, 32'd1);
        if (exp_a.size() > 0) begin
          check("r_data", {16'd0, a_if.r_data}, {16'd0, exp_a.pop_front()});
          check("one_clear_per_batch", clr_cnt, 32'd1);
          check("strobes_per_batch", strobe_cnt, 32'd4);
        end
        clr_cnt = 0;
      end
      prev_rv  = a_if.r_valid;
      prev_rr  = a_if.r_ready;
      prev_pw  = a_if.p_write;
      prev_pin = a_if.p_in;
      prev_pwt = a_if.p_weight;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_if.r_valid && b_if.r_ready) begin
      check("b_result_was_expected", {31'd0, exp_b.size() > 0}, 32'd1);
      if (exp_b.size() > 0) check("b_r_data", {16'd0, b_if.r_data}, {16'd0, exp_b.pop_front()});
    end
  end

  // Stimulus helpers; inputs change 1 time unit after a rising edge.
  int exp_sum;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [7:0] i, input logic [7:0] w);
    step();
    a_if.s_valid = 1'b1; a_if.s_in = i; a_if.s_weight = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_if.s_ready) begin
        step();
        a_if.s_valid = 1'b0;
        exp_sum += int'(i) * int'(w);
        return;
      end
    end
    check("accept_timeout", {31'd0, a_if.s_ready}, 32'd1);
    a_if.s_valid = 1'b0;
  endtask

  // Reference: result is the plain sum of products modulo 2^OW, or the forced value.
  task automatic push_expected();
    exp_a.push_back(force_ff ? 16'hFFFF : exp_sum[15:0]);
  endtask

  task automatic random_batch();
    exp_sum = 0;
    for (int n = 0; n < 4; n++) send_a(8'($urandom), 8'($urandom));
    push_expected();
  endtask

  task automatic drain_a();
    for (int k = 0; k < 500; k++) begin
      if (exp_a.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", exp_a.size(), 32'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_s_ready"},  {31'd0, a_if.s_ready}, 32'd0);
    check({tag, "_p_clr"},    {31'd0, a_if.p_clr},   32'd0);
    check({tag, "_p_write"},  {31'd0, a_if.p_write}, 32'd0);
    check({tag, "_r_valid"},  {31'd0, a_if.r_valid}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy_a},       32'd0);
    check({tag, "_p_in"},     {24'd0, a_if.p_in},    32'd0);
    check({tag, "_p_weight"}, {24'd0, a_if.p_weight}, 32'd0);
    check({tag, "_r_data"},   {16'd0, a_if.r_data},  32'd0);
  endtask

  initial begin
    int            strobe_at, rv_at;
    logic [OW-1:0] held;

    rst = 1'b1;
    a_if.s_valid = 1'b0; a_if.s_in = '0; a_if.s_weight = '0;
    b_if.s_valid = 1'b0; b_if.s_in = '0; b_if.s_weight = '0; b_if.r_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_reset_a("reset");
    step();
    rst = 1'b0;

    // Directed batch 8*8 + 8*9 + 8*10 + 8*11 = 304.
    exp_sum = 0;
    send_a(8'd8, 8'd8); send_a(8'd8, 8'd9); send_a(8'd8, 8'd10); send_a(8'd8, 8'd11);
    check("directed_sum_model", exp_sum, 32'd304);
    push_expected();
    drain_a();

    // Source stalls 3 cycles between pairs 2 and 3.
    exp_sum = 0;
    send_a(8'd1, 8'd2); send_a(8'd3, 8'd4);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_if.s_ready) break;
    end
    repeat (3) begin
      @(negedge clk);
      check("stall_p_write_low", {31'd0, a_if.p_write}, 32'd0);
      check("stall_s_ready_high", {31'd0, a_if.s_ready}, 32'd1);
    end
    send_a(8'd5, 8'd6); send_a(8'd7, 8'd8);
    push_expected();
    drain_a();

    // Consumer stalls 5 cycles in RESULT.
    rr_mode = 2;
    step();
    random_batch();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_if.r_valid) break;
    end
    check("stall_result_arrives", {31'd0, a_if.r_valid}, 32'd1);
    held = a_if.r_data;
    repeat (5) begin
      @(negedge clk);
      check("stall_r_valid_held", {31'd0, a_if.r_valid}, 32'd1);
      check("stall_r_data_stable", {16'd0, a_if.r_data}, {16'd0, held});
    end
    rr_mode = 0;
    drain_a();

    // Reset in the middle of a batch.
    exp_sum = 0;
    send_a(8'd1, 8'd1); send_a(8'd2, 8'd2);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_a("mid_reset");
    step();
    rst = 1'b0;
    random_batch();
    drain_a();

    // Percept result saturated at all ones passes through untouched.
    force_ff = 1'b1;
    random_batch();
    drain_a();
    force_ff = 1'b0;

    // Back-to-back random batches with random backpressure.
    rr_mode = 1;
    repeat (6) random_batch();
    drain_a();
    rr_mode = 0;

    // Single-pair, zero-wait instance: result two cycles after the strobe.
    step();
    b_if.s_valid = 1'b1; b_if.s_in = 8'd3; b_if.s_weight = 8'd5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_if.s_ready) break;
    end
    check("b_accept", {31'd0, b_if.s_ready}, 32'd1);
    step();
    b_if.s_valid = 1'b0;
    exp_b.push_back(16'd15);
    strobe_at = -1; rv_at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_if.p_write) strobe_at = k;
      if (b_if.r_valid) begin
        rv_at = k;
        break;
      end
    end
    check("b_result_latency", rv_at - strobe_at, 32'd2);
    step();
    @(negedge clk);
    check("b_scoreboard_empty", exp_b.size(), 32'd0);
    check("b_idle_after", {31'd0, busy_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
